// File: rtl/cache_mem_arbiter_if.sv
// Cache/RAM bus bundle for the cache-to-memory arbiter.
// slave: arbiter side. master: the caches + RAM model side (testbench).
interface cache_mem_arbiter_if #(
  parameter int WORD_W = 32
);
  // icache side
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;
  // dcache side
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;
  // RAM side
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;
  // status
  logic              err_abort;
  logic              gnt_d;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
           err_abort, gnt_d
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
           err_abort, gnt_d
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Single-ported RAM arbiter between icache and dcache.
// Data requests have strict priority; a grant is held until the RAM reports
// ACCESS, the requester withdraws/redirects, or MAX_RETRY ERRORs accumulate.
// All cache/RAM outputs are decoded from the registered state so that an
// asynchronous reset returns them to idle values immediately.
module cache_mem_arbiter #(
  parameter int WORD_W    = 32,
  parameter int MAX_RETRY = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  cache_mem_arbiter_if.slave  bus
);
  localparam int RC_W = $clog2(MAX_RETRY + 1);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, DACC, IFETCH} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] addr_q,  addr_d;
  logic [WORD_W-1:0] data_q,  data_d;
  logic              wr_q,    wr_d;
  logic [RC_W-1:0]   retry_q, retry_d;

  logic d_any;
  logic d_same_op;

  assign d_any = bus.dREN | bus.dWEN;
  // A latched write stays live only while dWEN is high; a latched read only
  // while it is still a plain read (dWEN rising turns it into a new request).
  assign d_same_op = wr_q ? bus.dWEN : (bus.dREN & ~bus.dWEN);

  // State, latched request and retry count registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      retry_q <= retry_d;
    end
  end

  // Arbitration, RAM strobes and cache responses
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    wr_d          = wr_q;
    retry_d       = retry_q;
    bus.iwait     = 1'b1;
    bus.iload     = '0;
    bus.dwait     = 1'b1;
    bus.dload     = '0;
    bus.ramREN    = 1'b0;
    bus.ramWEN    = 1'b0;
    bus.ramaddr   = '0;
    bus.ramstore  = '0;
    bus.err_abort = 1'b0;
    bus.gnt_d     = 1'b0;

    case (state_q)
      IDLE: begin
        retry_d = '0;
        if (d_any) begin
          addr_d  = bus.daddr;
          data_d  = bus.dstore;
          wr_d    = bus.dWEN;
          state_d = DACC;
        end else if (bus.iREN) begin
          addr_d  = bus.iaddr;
          wr_d    = 1'b0;
          state_d = IFETCH;
        end
      end

      DACC: begin
        bus.gnt_d    = 1'b1;
        bus.ramaddr  = addr_q;
        bus.ramstore = data_q;
        bus.ramWEN   = wr_q;
        bus.ramREN   = ~wr_q;
        // Redirect beats completion so a stale word never reaches the cache.
        if (d_any && bus.daddr != addr_q) begin
          state_d = IDLE;
        end else if (bus.ramstate == RS_ACCESS) begin
          bus.dwait = 1'b0;
          if (!wr_q) bus.dload = bus.ramload;
          state_d = IDLE;
        end else if (!d_same_op) begin
          state_d = IDLE;
        end else if (bus.ramstate == RS_ERROR) begin
          retry_d = retry_q + RC_W'(1);
          if (retry_q == RC_W'(MAX_RETRY - 1)) begin
            bus.err_abort = 1'b1;
            state_d       = IDLE;
          end
        end
      end

      IFETCH: begin
        bus.ramaddr = addr_q;
        bus.ramREN  = 1'b1;
        if (bus.iREN && bus.iaddr != addr_q) begin
          state_d = IDLE;
        end else if (bus.ramstate == RS_ACCESS) begin
          bus.iwait = 1'b0;
          bus.iload = bus.ramload;
          state_d   = IDLE;
        end else if (!bus.iREN) begin
          state_d = IDLE;
        end else if (bus.ramstate == RS_ERROR) begin
          retry_d = retry_q + RC_W'(1);
          if (retry_q == RC_W'(MAX_RETRY - 1)) begin
            bus.err_abort = 1'b1;
            state_d       = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter. Stimulus pushes the expected
// completion events (fetch done, data done, error abort) into a scoreboard;
// a forked monitor pops and compares whenever the DUT reports one.
module tb_cache_mem_arbiter;
  localparam logic [1:0] K_I = 2'd0, K_D = 2'd1, K_E = 2'd2;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic CLK;
  logic nRST;
  int   total;
  int   bad;
  ev_t  sb[$];

  cache_mem_arbiter_if #(.WORD_W(32)) bus ();

  cache_mem_arbiter #(.WORD_W(32), .MAX_RETRY(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input logic [1:0] k, input logic [31:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event kind=%0d got_data=%h want=none t=%0t", k, d, $time);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", {30'b0, k}, {30'b0, e.kind});
      chk("ev_addr", bus.ramaddr, e.addr);
      chk("ev_data", d, e.data);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    nRST  = 1'b0;
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramstate = FREE;

    // completion monitor
    fork
      forever begin
        @(negedge CLK);
        if (nRST) begin
          if (!bus.iwait)   pop_chk(K_I, bus.iload);
          if (!bus.dwait)   pop_chk(K_D, bus.dload);
          if (bus.err_abort) pop_chk(K_E, 32'h0);
        end
      end
    join_none

    // reset values
    neg();
    chk("rst_waits", {30'b0, bus.iwait, bus.dwait}, 32'h3);
    chk("rst_loads", bus.iload | bus.dload, 32'h0);
    chk("rst_strobes", {28'b0, bus.ramREN, bus.ramWEN, bus.err_abort, bus.gnt_d}, 32'h0);
    chk("rst_ramaddr", bus.ramaddr | bus.ramstore, 32'h0);
    step();
    nRST = 1'b1;

    // 1: fetch 0x40, two BUSY then ACCESS
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
    step(); neg();
    chk("t1_ren_c1", {31'b0, bus.ramREN}, 32'h1);
    chk("t1_addr_c1", bus.ramaddr, 32'h40);
    step(); neg();
    chk("t1_ren_c2", {31'b0, bus.ramREN}, 32'h1);
    step();
    bus.ramstate = ACC; bus.ramload = 32'hDEADBEEF;
    push(K_I, 32'h40, 32'hDEADBEEF);
    neg();
    chk("t1_ren_c3", {31'b0, bus.ramREN}, 32'h1);
    step();
    bus.iREN = 1'b0; bus.ramstate = FREE;
    neg();
    chk("t1_idle_ren", {31'b0, bus.ramREN}, 32'h0);

    // 2: simultaneous write and fetch; data wins, one IDLE gap, then fetch
    bus.iREN = 1'b1; bus.iaddr = 32'h200;
    bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'h1234;
    step(); neg();
    chk("t2_wen", {30'b0, bus.ramWEN, bus.ramREN}, 32'h2);
    chk("t2_store", bus.ramstore, 32'h1234);
    chk("t2_gnt", {31'b0, bus.gnt_d}, 32'h1);
    step();
    bus.ramstate = ACC;
    push(K_D, 32'h100, 32'h0);
    step();
    bus.dWEN = 1'b0; bus.ramstate = FREE;
    neg();
    chk("t2_gap", {29'b0, bus.ramREN, bus.ramWEN, bus.gnt_d}, 32'h0);
    step(); neg();
    chk("t2_fetch_addr", bus.ramaddr, 32'h200);
    chk("t2_fetch_ren", {31'b0, bus.ramREN}, 32'h1);
    step();
    bus.ramstate = ACC; bus.ramload = 32'hCAFEF00D;
    push(K_I, 32'h200, 32'hCAFEF00D);
    step();
    bus.iREN = 1'b0; bus.ramstate = FREE;

    // 3: read 0x80 hits ERROR four times -> abort; regrant starts with count 0
    bus.dREN = 1'b1; bus.daddr = 32'h80; bus.ramstate = ERR;
    step(); step(); step(); step();
    push(K_E, 32'h80, 32'h0);
    neg();
    chk("t3_dwait_held", {31'b0, bus.dwait}, 32'h1);
    step(); neg();
    chk("t3_idle", {30'b0, bus.gnt_d, bus.err_abort}, 32'h0);
    step(); step(); step(); step();
    bus.ramstate = ACC; bus.ramload = 32'h55AA;
    push(K_D, 32'h80, 32'h55AA);
    step();
    bus.dREN = 1'b0; bus.ramstate = FREE;

    // 4: fetch redirect 0x40 -> 0x80 while BUSY
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
    step(); neg();
    chk("t4_addr_old", bus.ramaddr, 32'h40);
    step();
    bus.iaddr = 32'h80; bus.ramload = 32'h11111111;
    step(); neg();
    chk("t4_drop", {31'b0, bus.ramREN}, 32'h0);
    step(); neg();
    chk("t4_addr_new", bus.ramaddr, 32'h80);
    step();
    bus.ramstate = ACC; bus.ramload = 32'h80808080;
    push(K_I, 32'h80, 32'h80808080);
    step();
    bus.iREN = 1'b0; bus.ramstate = FREE;

    // 5: dREN withdrawn while BUSY, pending fetch granted next
    bus.dREN = 1'b1; bus.daddr = 32'h300; bus.iREN = 1'b1; bus.iaddr = 32'h44;
    bus.ramstate = BUSY;
    step(); neg();
    chk("t5_dacc", {30'b0, bus.ramREN, bus.gnt_d}, 32'h3);
    step();
    bus.dREN = 1'b0;
    step(); neg();
    chk("t5_drop", {30'b0, bus.ramREN, bus.gnt_d}, 32'h0);
    step(); neg();
    chk("t5_fetch_addr", bus.ramaddr, 32'h44);
    step();
    bus.ramstate = ACC; bus.ramload = 32'h4444;
    push(K_I, 32'h44, 32'h4444);
    step();
    bus.iREN = 1'b0; bus.ramstate = FREE;

    // 6: async reset during a write
    bus.dWEN = 1'b1; bus.daddr = 32'h500; bus.dstore = 32'h77; bus.ramstate = BUSY;
    step(); neg();
    chk("t6_wen", {31'b0, bus.ramWEN}, 32'h1);
    #2 nRST = 1'b0;
    #1;
    chk("t6_rst_now", {29'b0, bus.ramWEN, bus.dwait, bus.gnt_d}, 32'h2);
    step();
    nRST = 1'b1;
    step(); neg();
    chk("t6_regrant", bus.ramaddr, 32'h500);
    chk("t6_regrant_wen", {31'b0, bus.ramWEN}, 32'h1);
    step();
    bus.ramstate = ACC;
    push(K_D, 32'h500, 32'h0);
    step();
    bus.dWEN = 1'b0; bus.ramstate = FREE;

    step(); step(); neg();
    chk("sb_drained", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
